// File: rtl/param_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_e;

  // Index width for an n-wide vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [4:0] oh2idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = idx | 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/param_rr_arbiter_if.sv
// Request/grant bundle between requesting masters and the arbiter.
interface param_rr_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N = 4
);
  localparam int IDW = idx_w(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  modport master (output req, input gnt, gnt_id, gnt_valid);
  modport slave  (input req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/param_rr_arbiter_enc.sv
// N-bit LSB-first priority encoder: index of the lowest set bit plus valid.
module lsb_prio_enc_n
  import rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idx_w(N)
) (
  input  logic [N-1:0]   vec,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, holds while owner requests,
// optional MAX_HOLD tenure limit forcing rotation to the next requester.
module param_rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst,
  param_rr_arbiter_if.slave  bus
);

  localparam int IDW = idx_w(N);
  localparam int CW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  state_e         state;
  logic [IDW-1:0] last;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   gnt_q;

  logic [N-1:0]   masked;
  logic [IDW-1:0] m_idx, u_idx, winner;
  logic           m_vld, u_vld;
  logic           hold_ok;

  // Only requesters strictly above the last winner are eligible first.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++)
      masked[i] = bus.req[i] && (i > int'(last));
  end

  lsb_prio_enc_n #(.N(N), .IDW(IDW)) u_enc_masked (
    .vec(masked), .idx(m_idx), .valid(m_vld)
  );

  lsb_prio_enc_n #(.N(N), .IDW(IDW)) u_enc_plain (
    .vec(bus.req), .idx(u_idx), .valid(u_vld)
  );

  assign winner  = m_vld ? m_idx : u_idx;
  assign hold_ok = (MAX_HOLD == 0) || (int'(cnt) < MAX_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= IDW'(N - 1);
      cnt   <= '0;
      gnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (u_vld) begin
            state <= GRANT;
            gnt_q <= N'(1) << winner;
            last  <= winner;
            cnt   <= CW'(1);
          end
        end
        GRANT: begin
          if (bus.req[last] && hold_ok) begin
            if (MAX_HOLD != 0) cnt <= cnt + CW'(1);
          end else if (u_vld) begin
            // Release or tenure expiry: hand off on this same edge.
            gnt_q <= N'(1) << winner;
            last  <= winner;
            cnt   <= CW'(1);
          end else begin
            state <= IDLE;
            gnt_q <= '0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = IDW'(oh2idx(32'(gnt_q)));

endmodule

// File: doc/param_rr_arbiter.md
# param_rr_arbiter

Parametrised round-robin arbiter for N requesters with registered one-hot grant, grant holding while the winner keeps requesting, and an optional hold limit that forces rotation. Next generation of the fixed 4-bit LSB priority encoder path: it arbitrates any width, remembers the last winner and adds starvation protection. It sits between the requesting masters and the shared resource, in front of the resource mux select.

## Interface
- N, default 4: number of requesters; legal range 2..32.
- MAX_HOLD, default 0: maximum consecutive grant cycles per tenure; 0 = unlimited.
- IDW, default $clog2(N): width of the grant index (derived; do not override).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all-zero when no grant.
- gnt_id  output  IDW  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high when gnt is non-zero.

## Operation
- States: IDLE (no grant), GRANT (one requester owns the resource).
- Pointer `last` (IDW bits) holds the most recent winner; reset value N-1, so requester 0 has top priority after reset.
- Candidate selection (combinational): masked = req with bits 0..last cleared. If masked != 0, winner = lowest set bit of masked; else winner = lowest set bit of req. No request -> no winner.
- IDLE: if any req bit set, go to GRANT on next edge with gnt = one-hot(winner), last = winner, hold counter = 1. Else stay.
- GRANT, owner still requesting and (MAX_HOLD = 0 or counter < MAX_HOLD): keep grant, counter += 1 (saturating).
- GRANT, owner drops req: re-arbitrate the same edge; if winner exists, grant it directly (zero-bubble handoff, counter = 1); else go to IDLE, gnt = 0.
- GRANT, MAX_HOLD reached while owner still requesting: re-arbitrate with the owner as `last`; if the owner is the only requester it is re-granted (counter = 1); otherwise next requester above it wins.
- gnt is always one-hot or zero; gnt_id and gnt_valid are consistent with gnt in the same cycle.
- Requests are level-sensitive; a requester de-asserting without ever being granted is simply dropped.
- Counter width $clog2(MAX_HOLD+1) (1 bit minimum when MAX_HOLD = 0; unused).

## Timing
- Reset (async assert, sync-safe deassert by system): gnt = 0, gnt_id = 0, gnt_valid = 0, last = N-1, counter = 0, state IDLE.
- Latency: req seen at edge k -> gnt valid after edge k (one-cycle registered grant).
- Handoff: owner req low in cycle k -> new owner's gnt visible after edge k; no idle cycle between owners.
- Tenure with MAX_HOLD = M: owner holds gnt for exactly M cycles when contended.
- Reset mid-grant: gnt drops immediately (asynchronous), pointer returns to N-1.
- Wrap-around: last = N-1 -> masked is empty -> search from bit 0.
- Simultaneous new requests arriving in the same cycle as owner release participate in that cycle's arbitration.

## Structure
- Shared package `rr_arb_pkg`: state enum (IDLE, GRANT), function for index width, one-hot-to-index helper.
- Sub-module `lsb_prio_enc_n` (parameter N): N-bit LSB-first priority encoder, outputs index and valid; instantiated twice (masked and unmasked vectors).
- Top holds state register, `last` pointer, hold counter and grant registers.

## Test plan
- Reset: rst high with req = 4'b1111 -> gnt = 0, gnt_valid = 0; release rst -> after one edge gnt = 4'b0001, gnt_id = 0.
- Rotation (N=4, MAX_HOLD=0): req = 4'b1111, each owner drops req for one cycle after being granted -> grant order 0,1,2,3,0 with no idle cycles.
- Wrap-around: last = 3, req = 4'b0110 -> gnt = 4'b0010; then req = 4'b0100 only -> gnt = 4'b0100.
- Hold limit (MAX_HOLD=4): req = 4'b0011 held constant -> gnt = 0001 for 4 cycles, 0010 for 4 cycles, repeating.
- Single requester with hold limit: req = 4'b1000 constant, MAX_HOLD=4 -> gnt stays 4'b1000 continuously, gnt_valid never drops.
- Async reset mid-grant: gnt = 4'b0100, assert rst between edges -> gnt = 0 immediately; after release with req = 4'b0100 -> gnt = 4'b0100 one edge later.
